fetch_unit: RTL and testbench

Instruction-fetch stage of the MIPS core. It owns the architectural PC register and drives it to the next-PC logic. It fetches one instruction at a time from instruction memory over a request/grant/response handshake, and presents it to decode with a valid/ready handshake. When decode accepts the instruction, the PC loads the next-PC value; a flush aborts any fetch in flight and restarts at a supplied address.

---
 rtl/fetch_unit.sv | 136 +++++++++++++
 tb/tb_fetch_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Owns the architectural PC, fetches one
// instruction at a time over a req/gnt/rvalid memory handshake and hands it
// to decode over a valid/ready handshake.
//
// Handshakes:
//   memory : imem_req is held with a stable imem_addr until imem_gnt; exactly
//            one response (imem_rvalid) is owed per grant, arriving at least
//            one cycle later. Only one request is outstanding at a time.
//   decode : instr_valid/instr are held stable until id_ready is seen high
//            in the same cycle; that cycle is the transfer.
//
// Optional feature: define FETCH_PERF_EN to add the perf_fetched and
// perf_flushed event counters and their ports.
//
// dbg_state exposes the FSM state with a fixed encoding:
//   IDLE=0, REQ=1, WAIT=2, HOLD=3, DRAIN=4.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] npc,
    output logic [31:0] pc,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    input  logic        id_ready,
`ifdef FETCH_PERF_EN
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_flushed,
`endif
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    state_t      state, state_nxt;
    logic        pc_load;
    logic [31:0] pc_nxt;
    logic        instr_load;
    logic        handshake;

    // Next-state, PC update and capture decisions; flush overrides everything.
    always_comb begin
        state_nxt  = state;
        pc_load    = 1'b0;
        pc_nxt     = pc;
        instr_load = 1'b0;
        handshake  = 1'b0;
        if (flush) begin
            pc_load = 1'b1;
            pc_nxt  = {flush_pc[31:2], 2'b00};
            case (state)
                IDLE:    state_nxt = REQ;
                REQ:     state_nxt = imem_gnt ? DRAIN : REQ;
                WAIT:    state_nxt = imem_rvalid ? REQ : DRAIN;
                HOLD:    state_nxt = REQ;
                DRAIN:   state_nxt = imem_rvalid ? REQ : DRAIN;
                default: state_nxt = IDLE;
            endcase
        end else begin
            case (state)
                IDLE: state_nxt = REQ;
                REQ: begin
                    if (imem_gnt) state_nxt = WAIT;
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        instr_load = 1'b1;
                        state_nxt  = HOLD;
                    end
                end
                HOLD: begin
                    if (id_ready) begin
                        handshake = 1'b1;
                        pc_load   = 1'b1;
                        pc_nxt    = {npc[31:2], 2'b00};
                        state_nxt = REQ;
                    end
                end
                DRAIN: begin
                    // Response owed by an aborted fetch: swallow it.
                    if (imem_rvalid) state_nxt = REQ;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State, PC and instruction registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            pc    <= {RESET_PC[31:2], 2'b00};
            instr <= 32'h0;
        end else begin
            state <= state_nxt;
            if (pc_load)    pc    <= pc_nxt;
            if (instr_load) instr <= imem_rdata;
        end
    end

`ifdef FETCH_PERF_EN
    // Event counters: delivered instructions and flushes seen outside IDLE.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_fetched <= 32'h0;
            perf_flushed <= 32'h0;
        end else begin
            if (handshake)                perf_fetched <= perf_fetched + 32'd1;
            if (flush && (state != IDLE)) perf_flushed <= perf_flushed + 32'd1;
        end
    end
`endif

    // Moore outputs decoded from the state register.
    always_comb begin
        imem_req    = (state == REQ);
        instr_valid = (state == HOLD);
        imem_addr   = pc;
        dbg_state   = state;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed, table-driven bench for fetch_unit.
// Each table row is one clock cycle: the inputs applied in that cycle and the
// state / PC / instruction expected to be visible during that cycle.
module tb_fetch_unit;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    localparam logic [31:0] A1 = 32'h1111_0001;
    localparam logic [31:0] A2 = 32'h2222_0002;
    localparam logic [31:0] A3 = 32'h3333_0003;
    localparam logic [31:0] A4 = 32'h4444_0004;
    localparam logic [31:0] A5 = 32'h5555_0005;
    localparam logic [31:0] A6 = 32'h6666_0006;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] npc;
    logic [31:0] pc;
    logic        flush;
    logic [31:0] flush_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic        id_ready;
    logic [2:0]  dbg_state;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        rdy;
        logic        fl;
        logic [31:0] fpc;
        logic [31:0] npc;
        logic [2:0]  st;
        logic [31:0] pc;
        logic [31:0] ins;
    } vec_t;

    vec_t vecs[$];

    fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .npc         (npc),
        .pc          (pc),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .id_ready    (id_ready),
`ifdef FETCH_PERF_EN
        .perf_fetched(perf_fetched),
        .perf_flushed(perf_flushed),
`endif
        .dbg_state   (dbg_state)
    );

    // Clock: 10 ns period, active edge at 5, 15, ...
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push(input logic g, input logic r, input logic [31:0] d,
                        input logic y, input logic f, input logic [31:0] fp,
                        input logic [31:0] np, input logic [2:0] s,
                        input logic [31:0] p, input logic [31:0] i);
        vec_t v;
        v.gnt = g; v.rv = r; v.rdata = d; v.rdy = y; v.fl = f;
        v.fpc = fp; v.npc = np; v.st = s; v.pc = p; v.ins = i;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        imem_gnt    = v.gnt;
        imem_rvalid = v.rv;
        imem_rdata  = v.rdata;
        id_ready    = v.rdy;
        flush       = v.fl;
        flush_pc    = v.fpc;
        npc         = v.npc;
    endtask

    task automatic idle_inputs();
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        id_ready = 1'b0; flush = 1'b0; flush_pc = 32'h0; npc = 32'h0;
    endtask

    initial begin
        //    gnt rv rdata         rdy fl fpc           npc           state    pc            instr
        push(0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        S_IDLE,  32'h3000,     32'h0); // c0
        push(1, 0, 32'h0,        0, 0, 32'h0,        32'h0,        S_REQ,   32'h3000,     32'h0);
        push(0, 1, A1,           0, 0, 32'h0,        32'h0,        S_WAIT,  32'h3000,     32'h0);
        push(0, 0, 32'h0,        1, 0, 32'h0,        32'h3004,     S_HOLD,  32'h3000,     A1);
        push(1, 0, 32'h0,        0, 0, 32'h0,        32'h0,        S_REQ,   32'h3004,     A1);    // c4
        push(0, 1, A2,           0, 0, 32'h0,        32'h0,        S_WAIT,  32'h3004,     A1);
        push(0, 0, 32'h0,        1, 0, 32'h0,        32'h3008,     S_HOLD,  32'h3004,     A2);
        push(1, 0, 32'h0,        0, 0, 32'h0,        32'h0,        S_REQ,   32'h3008,     A2);
        push(0, 1, A3,           0, 0, 32'h0,        32'h0,        S_WAIT,  32'h3008,     A2);    // c8
        // decode backpressure: four cycles of id_ready low in HOLD
        for (int k = 0; k < 4; k++)
            push(0, 0, 32'h0,    0, 0, 32'h0,        32'h300C,     S_HOLD,  32'h3008,     A3);
        push(0, 0, 32'h0,        1, 0, 32'h0,        32'h300C,     S_HOLD,  32'h3008,     A3);    // c13
        push(1, 0, 32'h0,        0, 0, 32'h0,        32'h0,        S_REQ,   32'h300C,     A3);
        // flush in WAIT without rvalid -> DRAIN; late data must be swallowed
        push(0, 0, 32'h0,        0, 1, 32'h4000,     32'h0,        S_WAIT,  32'h300C,     A3);    // c15
        push(0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        S_DRAIN, 32'h4000,     A3);
        push(0, 1, 32'hDEADBEEF, 0, 0, 32'h0,        32'h0,        S_DRAIN, 32'h4000,     A3);
        push(1, 0, 32'h0,        0, 0, 32'h0,        32'h0,        S_REQ,   32'h4000,     A3);
        push(0, 1, A4,           0, 0, 32'h0,        32'h0,        S_WAIT,  32'h4000,     A3);
        // flush in HOLD with id_ready: no handshake, npc ignored, unaligned flush_pc
        push(0, 0, 32'h0,        1, 1, 32'h5002,     32'h4004,     S_HOLD,  32'h4000,     A4);    // c20
        // grant stall: five cycles, flush on the last one changes the address
        for (int k = 0; k < 4; k++)
            push(0, 0, 32'h0,    0, 0, 32'h0,        32'h0,        S_REQ,   32'h5000,     A4);
        push(0, 0, 32'h0,        0, 1, 32'h6000,     32'h0,        S_REQ,   32'h5000,     A4);    // c25
        push(1, 0, 32'h0,        0, 0, 32'h0,        32'h0,        S_REQ,   32'h6000,     A4);
        push(0, 1, A5,           0, 0, 32'h0,        32'h0,        S_WAIT,  32'h6000,     A4);
        push(0, 0, 32'h0,        1, 0, 32'h0,        32'h6004,     S_HOLD,  32'h6000,     A5);
        // flush with grant -> DRAIN; flush again in DRAIN together with rvalid
        push(1, 0, 32'h0,        0, 1, 32'h7000,     32'h0,        S_REQ,   32'h6004,     A5);    // c29
        push(0, 1, 32'hBAD0BAD0, 0, 1, 32'h7100,     32'h0,        S_DRAIN, 32'h7000,     A5);
        push(1, 0, 32'h0,        0, 0, 32'h0,        32'h0,        S_REQ,   32'h7100,     A5);
        // flush in WAIT coincident with rvalid: data dropped, straight to REQ
        push(0, 1, 32'hBAD1BAD1, 0, 1, 32'h8000,     32'h0,        S_WAIT,  32'h7100,     A5);    // c32
        // stray rvalid in REQ is ignored
        push(0, 1, 32'hBAD2BAD2, 0, 0, 32'h0,        32'h0,        S_REQ,   32'h8000,     A5);
        push(1, 0, 32'h0,        0, 0, 32'h0,        32'h0,        S_REQ,   32'h8000,     A5);
        push(0, 1, A6,           0, 0, 32'h0,        32'h0,        S_WAIT,  32'h8000,     A5);
        // npc with low bits set near the top of the address space
        push(0, 0, 32'h0,        1, 0, 32'h0,        32'hFFFF_FFFF, S_HOLD, 32'h8000,     A6);    // c36
        push(0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        S_REQ,   32'hFFFF_FFFC, A6);

        // reset block
        rstn = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clk);
        check("reset_state", {29'h0, dbg_state}, {29'h0, S_IDLE});
        check("reset_req", {31'h0, imem_req}, 32'h0);
        check("reset_valid", {31'h0, instr_valid}, 32'h0);
        check("reset_pc", pc, 32'h3000);
        check("reset_instr", instr, 32'h0);
        rstn = 1'b1;

        // table: drive one row per cycle, compare away from the rising edge
        foreach (vecs[i]) begin
            drive(vecs[i]);
            #1;
            check($sformatf("v%0d_state", i), {29'h0, dbg_state}, {29'h0, vecs[i].st});
            check($sformatf("v%0d_req", i), {31'h0, imem_req}, {31'h0, vecs[i].st == S_REQ});
            check($sformatf("v%0d_valid", i), {31'h0, instr_valid}, {31'h0, vecs[i].st == S_HOLD});
            check($sformatf("v%0d_pc", i), pc, vecs[i].pc);
            check($sformatf("v%0d_addr", i), imem_addr, vecs[i].pc);
            check($sformatf("v%0d_instr", i), instr, vecs[i].ins);
            @(negedge clk);
        end
        idle_inputs();

`ifdef FETCH_PERF_EN
        // handshakes at c3,c6,c13,c28,c36; flushes outside IDLE at c15,c20,c25,c29,c30,c32
        #1;
        check("perf_fetched", perf_fetched, 32'd5);
        check("perf_flushed", perf_flushed, 32'd6);
`endif

        // asynchronous reset mid-cycle, away from any clock edge
        #3;
        rstn = 1'b0;
        #1;
        check("async_state", {29'h0, dbg_state}, {29'h0, S_IDLE});
        check("async_req", {31'h0, imem_req}, 32'h0);
        check("async_pc", pc, 32'h3000);
        check("async_instr", instr, 32'h0);
`ifdef FETCH_PERF_EN
        check("async_fetched", perf_fetched, 32'h0);
        check("async_flushed", perf_flushed, 32'h0);
`endif

        // flush in IDLE: not counted, PC taken from flush_pc
        @(negedge clk);
        rstn     = 1'b1;
        flush    = 1'b1;
        flush_pc = 32'h9000;
        #1;
        check("idle_flush_state", {29'h0, dbg_state}, {29'h0, S_IDLE});
        @(negedge clk);
        idle_inputs();
        #1;
        check("idle_flush_next", {29'h0, dbg_state}, {29'h0, S_REQ});
        check("idle_flush_pc", pc, 32'h9000);
        check("idle_flush_req", {31'h0, imem_req}, 32'h1);
`ifdef FETCH_PERF_EN
        check("idle_flush_cnt", perf_flushed, 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
